cam_power_seq: RTL and testbench

Parametrised power-up/power-down sequencer for one OmniVision-class camera sensor (OV5640 family).
- Drives PWDN, RESET_N and the XCLK gate with programmable timing.
- Supports orderly shutdown and a soft restart, and reports status.
- Sits between the board-level enable switch and the camera datapath; power_done releases reset to the SCCB configurator and capture logic.

---
 rtl/cam_pwr_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/cam_power_seq.sv | 154 +++++++++++++++
 tb/tb_cam_power_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pwr_pkg.sv
// Shared definitions for the camera power sequencer: state encodings and
// elaboration-time helpers for converting microsecond timings to cycles.
package cam_pwr_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_PWDN_WAIT = 3'd1,
        ST_RST_WAIT  = 3'd2,
        ST_INIT_WAIT = 3'd3,
        ST_READY     = 3'd4,
        ST_SHUTDOWN  = 3'd5
    } cam_state_t;

    // freq must be a whole number of MHz, so the division is exact.
    function automatic int us_to_cyc(input int freq, input int us);
        return (freq / 1_000_000) * us;
    endfunction

    function automatic int cnt_width(input int max_cycles);
        return $clog2(max_cycles) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single slow asynchronous level (switches, enables).
// Both flops clear to 0 on reset.
module sync_2ff (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cam_power_seq.sv
// Power-up / power-down sequencer for an OV5640-class sensor: orders XCLK,
// PWDN and RESET_N with programmable holds and reports readiness.
module cam_power_seq
    import cam_pwr_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int T_PWDN_US   = 6000,
    parameter int T_RST_US    = 2000,
    parameter int T_INIT_US   = 21000,
    parameter int T_OFF_US    = 1000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       pwr_en,
    input  logic       soft_restart,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       xclk_en,
    output logic       power_done,
    output logic       busy,
    output logic [2:0] state_o
);

    localparam int CYC_PWDN = us_to_cyc(CLK_FREQ_HZ, T_PWDN_US);
    localparam int CYC_RST  = us_to_cyc(CLK_FREQ_HZ, T_RST_US);
    localparam int CYC_INIT = us_to_cyc(CLK_FREQ_HZ, T_INIT_US);
    localparam int CYC_OFF  = us_to_cyc(CLK_FREQ_HZ, T_OFF_US);

    localparam int CYC_MAX_A = (CYC_PWDN > CYC_RST)  ? CYC_PWDN : CYC_RST;
    localparam int CYC_MAX_B = (CYC_INIT > CYC_OFF)  ? CYC_INIT : CYC_OFF;
    localparam int CYC_MAX   = (CYC_MAX_A > CYC_MAX_B) ? CYC_MAX_A : CYC_MAX_B;
    localparam int CNT_W     = cnt_width(CYC_MAX);

    localparam logic [CNT_W-1:0] LAST_PWDN = CNT_W'(CYC_PWDN - 1);
    localparam logic [CNT_W-1:0] LAST_RST  = CNT_W'(CYC_RST - 1);
    localparam logic [CNT_W-1:0] LAST_INIT = CNT_W'(CYC_INIT - 1);
    localparam logic [CNT_W-1:0] LAST_OFF  = CNT_W'(CYC_OFF - 1);

    cam_state_t       state_q;
    cam_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pen;
    logic             pwdn_d;
    logic             rst_n_d;
    logic             xclk_d;
    logic             done_d;
    logic             busy_d;

    sync_2ff u_pen_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .d         (pwr_en),
        .q         (pen)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            cam_pwdn   <= 1'b1;
            cam_rst_n  <= 1'b0;
            xclk_en    <= 1'b0;
            power_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cam_pwdn   <= pwdn_d;
            cam_rst_n  <= rst_n_d;
            xclk_en    <= xclk_d;
            power_done <= done_d;
            busy       <= busy_d;
        end
    end

    // Dropping pen is checked before any timeout so it wins a same-cycle tie.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF: begin
                if (pen) state_d = ST_PWDN_WAIT;
            end
            ST_PWDN_WAIT: begin
                if (!pen)                    state_d = ST_OFF;
                else if (cnt_q == LAST_PWDN) state_d = ST_RST_WAIT;
            end
            ST_RST_WAIT: begin
                if (!pen)                   state_d = ST_SHUTDOWN;
                else if (cnt_q == LAST_RST) state_d = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                if (!pen)                    state_d = ST_SHUTDOWN;
                else if (cnt_q == LAST_INIT) state_d = ST_READY;
            end
            ST_READY: begin
                if (!pen || soft_restart) state_d = ST_SHUTDOWN;
            end
            ST_SHUTDOWN: begin
                if (cnt_q == LAST_OFF) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Counter restarts on every state entry and idles at zero in untimed states.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if ((state_d != state_q) || (state_q == ST_OFF) || (state_q == ST_READY)) begin
            cnt_d = '0;
        end
    end

    // Outputs decode the next state so the registered pins change with state_q.
    always_comb begin
        pwdn_d  = 1'b1;
        rst_n_d = 1'b0;
        xclk_d  = 1'b0;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        case (state_d)
            ST_PWDN_WAIT: begin
                xclk_d = 1'b1;
                busy_d = 1'b1;
            end
            ST_RST_WAIT: begin
                pwdn_d = 1'b0;
                xclk_d = 1'b1;
                busy_d = 1'b1;
            end
            ST_INIT_WAIT: begin
                pwdn_d  = 1'b0;
                rst_n_d = 1'b1;
                xclk_d  = 1'b1;
                busy_d  = 1'b1;
            end
            ST_READY: begin
                pwdn_d  = 1'b0;
                rst_n_d = 1'b1;
                xclk_d  = 1'b1;
                done_d  = 1'b1;
            end
            ST_SHUTDOWN: begin
                pwdn_d = 1'b0;
                xclk_d = 1'b1;
                busy_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_cam_power_seq.sv
// Bench for cam_power_seq: directed power-up/down scenarios plus a random
// pwr_en / soft_restart phase, all checked against a timeline-based model.
module tb_cam_power_seq;

    localparam int C_PWDN  = 6;
    localparam int C_RST   = 2;
    localparam int C_INIT  = 21;
    localparam int C_OFF   = 3;
    localparam int T_READY = C_PWDN + C_RST + C_INIT;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       pwr_en = 1'b0;
    logic       soft_restart = 1'b0;
    logic       cam_pwdn;
    logic       cam_rst_n;
    logic       xclk_en;
    logic       power_done;
    logic       busy;
    logic [2:0] state_o;

    int tests = 0;
    int fails = 0;

    // Model: mode 0 = off, 1 = powering/powered (m_e = edges since start),
    // 2 = shutting down (m_e = edges since shutdown began).
    int   m_mode = 0;
    int   m_e = 0;
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;

    cam_power_seq #(
        .CLK_FREQ_HZ (1_000_000),
        .T_PWDN_US   (6),
        .T_RST_US    (2),
        .T_INIT_US   (21),
        .T_OFF_US    (3)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .pwr_en       (pwr_en),
        .soft_restart (soft_restart),
        .cam_pwdn     (cam_pwdn),
        .cam_rst_n    (cam_rst_n),
        .xclk_en      (xclk_en),
        .power_done   (power_done),
        .busy         (busy),
        .state_o      (state_o)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [7:0] exp_vec();
        logic [2:0] st;
        if (m_mode == 0)                   st = 3'd0;
        else if (m_mode == 2)              st = 3'd5;
        else if (m_e < C_PWDN)             st = 3'd1;
        else if (m_e < C_PWDN + C_RST)     st = 3'd2;
        else if (m_e < T_READY)            st = 3'd3;
        else                               st = 3'd4;
        return {st, (st <= 3'd1), (st == 3'd3 || st == 3'd4), (st != 3'd0),
                (st == 3'd4), !(st == 3'd0 || st == 3'd4)};
    endfunction

    function automatic logic [7:0] obs_vec();
        return {state_o, cam_pwdn, cam_rst_n, xclk_en, power_done, busy};
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_e    = 0;
        m_s1   = 1'b0;
        m_s2   = 1'b0;
    endtask

    // The sequencer acts on pwr_en as it stood two edges earlier.
    task automatic model_edge();
        logic p;
        if (!sys_rst_n) begin
            model_reset();
            return;
        end
        p    = m_s2;
        m_s2 = m_s1;
        m_s1 = pwr_en;
        case (m_mode)
            0: if (p) begin m_mode = 1; m_e = 0; end
            1: begin
                if (!p) begin
                    m_mode = (m_e < C_PWDN) ? 0 : 2;
                    m_e    = 0;
                end else if (m_e >= T_READY && soft_restart) begin
                    m_mode = 2;
                    m_e    = 0;
                end else if (m_e < T_READY) begin
                    m_e++;
                end
            end
            default: begin
                if (m_e == C_OFF - 1) begin m_mode = 0; m_e = 0; end
                else m_e++;
            end
        endcase
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        logic [7:0] obs;
        logic [7:0] exp;
        @(posedge sys_clk);
        model_edge();
        #1;
        obs = obs_vec();
        exp = exp_vec();
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b (state,pwdn,rst_n,xclk,done,busy)",
                   tag, obs, exp);
        end
    endtask

    // Raises pwr_en just after an edge (edge 0) and checks the power-up milestones.
    task automatic run_powerup(input string tag);
        int x_rise    = -1;
        int pd_fall   = -1;
        int rn_rise   = -1;
        int done_rise = -1;
        int busy_bad  = 0;
        pwr_en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step({tag, "_seq"});
            if (xclk_en    && x_rise    < 0) x_rise    = k;
            if (!cam_pwdn  && pd_fall   < 0) pd_fall   = k;
            if (cam_rst_n  && rn_rise   < 0) rn_rise   = k;
            if (power_done && done_rise < 0) done_rise = k;
            if (busy !== (k >= 3 && k <= 31)) busy_bad++;
        end
        check({tag, "_xclk_edge"}, x_rise, 3);
        check({tag, "_pwdn_fall_edge"}, pd_fall, 9);
        check({tag, "_rst_rise_edge"}, rn_rise, 11);
        check({tag, "_done_edge"}, done_rise, 32);
        check({tag, "_busy_window_errs"}, busy_bad, 0);
    endtask

    initial begin
        int done_k;
        int rn_rose;
        int saw_shut;

        // 1: reset held with pwr_en low
        model_reset();
        for (int k = 0; k < 50; k++) step("reset_hold");
        sys_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) step("idle_off");

        // 2: full power-up
        run_powerup("powerup");

        // 3: orderly shutdown from READY
        pwr_en = 1'b0;
        repeat (3) step("shutdown");
        check("shut_rst_n", int'(cam_rst_n), 0);
        check("shut_done", int'(power_done), 0);
        check("shut_pwdn_low", int'(cam_pwdn), 0);
        repeat (3) step("shutdown");
        check("off_pwdn", int'(cam_pwdn), 1);
        check("off_xclk", int'(xclk_en), 0);
        check("off_state", int'(state_o), 0);

        // 4: soft restart from READY
        pwr_en = 1'b1;
        repeat (36) step("to_ready");
        check("ready_before_restart", int'(state_o), 4);
        soft_restart = 1'b1;
        step("restart");
        soft_restart = 1'b0;
        done_k = power_done ? 1 : -1;
        for (int k = 2; k <= 60 && done_k < 0; k++) begin
            step("restart");
            if (power_done) done_k = k;
        end
        check("restart_done_edge", done_k, 34);

        // 5: abort during PWDN_WAIT
        pwr_en = 1'b0;
        repeat (10) step("to_off");
        pwr_en = 1'b1;
        repeat (3) step("abort");
        pwr_en = 1'b0;
        rn_rose  = 0;
        saw_shut = 0;
        for (int k = 4; k <= 14; k++) begin
            step("abort");
            if (cam_rst_n) rn_rose = 1;
            if (state_o == 3'd5) saw_shut = 1;
            if (k == 6) check("abort_off_edge6", int'(state_o), 0);
        end
        check("abort_rst_rose", rn_rose, 0);
        check("abort_saw_shutdown", saw_shut, 0);

        // 6: asynchronous reset during INIT_WAIT, then replay
        pwr_en = 1'b1;
        repeat (15) step("to_init");
        check("in_init", int'(state_o), 3);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("async_rst_outputs", int'(obs_vec()), int'(8'b000_1_0_0_0_0));
        model_reset();
        repeat (4) step("rst_mid");
        sys_rst_n = 1'b1;
        run_powerup("replay");

        // Random pwr_en toggles and soft_restart pulses
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 39) == 0) pwr_en = ~pwr_en;
            soft_restart = ($urandom_range(0, 11) == 0);
            step("random");
        end
        soft_restart = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
